// File: rtl/alu_pkg.sv
// Shared definitions for the toy ALU datapath blocks: divider state encoding
// and the divide-by-zero result constant.
package alu_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_MAX_W = 64;

    // All-ones quotient reported for a zero divisor; sliced to the divider width.
    localparam logic [DIV_MAX_W-1:0] DBZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, built as a + ~b + 1 with 4-bit carry-lookahead groups.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    // Widened to whole 4-bit groups; the shifted remainder needs WIDTH+1 bits.
    localparam int AW = WIDTH + 4;
    localparam int NG = AW / 4;

    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] s;
    logic [NG:0]   gc;
    logic          unused_hi;

    assign a     = {3'b000, r, q_msb};
    assign b     = ~{4'b0000, d};
    assign gc[0] = 1'b1;

    for (genvar g = 0; g < NG; g++) begin : g_cla
        logic [3:0] ga;
        logic [3:0] gb;
        logic [3:0] gg;
        logic [3:0] gp;
        logic [4:0] c;

        assign ga   = a[4*g +: 4];
        assign gb   = b[4*g +: 4];
        assign gg   = ga & gb;
        assign gp   = ga ^ gb;
        assign c[0] = gc[g];
        assign c[1] = gg[0] | (gp[0] & c[0]);
        assign c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
        assign c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                    | (gp[2] & gp[1] & gp[0] & c[0]);
        assign c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                    | (gp[3] & gp[2] & gp[1] & gg[0])
                    | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);

        assign s[4*g +: 4] = gp ^ c[3:0];
        assign gc[g+1]     = c[4];
    end

    // Carry out of the full-width subtract means no borrow: the divisor fits.
    assign q_bit  = gc[NG];
    assign r_next = q_bit ? s[WIDTH-1:0] : a[WIDTH-1:0];

    assign unused_hi = ^{s[AW-1:WIDTH], a[AW-1:WIDTH]};

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// valid/ready handshake on request and result.
module div_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state;
    div_state_e       state_nx;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;
    logic             accept;
    logic             last;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r),
        .q_msb  (q[WIDTH-1]),
        .d      (d),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                if (divisor == '0) begin
                    quotient    <= DBZ_QUOT[WIDTH-1:0];
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else begin
                    r           <= '0;
                    q           <= dividend;
                    d           <= divisor;
                    cnt         <= CW'(WIDTH - 1);
                    div_by_zero <= 1'b0;
                end
            end else if (state == CALC) begin
                r   <= r_next;
                q   <= {q[WIDTH-2:0], q_bit};
                cnt <= cnt - CW'(1);
                // Final step: publish the completed quotient and remainder.
                if (last) begin
                    quotient  <= {q[WIDTH-2:0], q_bit};
                    remainder <= r_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: hand-computed quotients/remainders, latency,
// backpressure, divide-by-zero and mid-operation reset.
module tb_div_iter;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    div_iter #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for the result, check it, then consume it.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int ecyc);
        int cyc;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(ecyc));
        chk({tag, ".quot"}, 64'(quotient), 64'(eq));
        chk({tag, ".rem"}, 64'(remainder), 64'(er));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
        chk({tag, ".busy"}, 64'(in_ready), 64'd0);
        if (b != '0) begin
            chk({tag, ".inv"}, 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
            chk({tag, ".rem_lt"}, 64'(remainder < b), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.quot", 64'(quotient), 64'd0);
        chk("rst.rem", 64'(remainder), 64'd0);
        chk("rst.dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("d100_7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, W + 1);
        run_op("dmax_1",   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, W + 1);
        run_op("dmsb_max", 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, W + 1);
        run_op("dbig",     32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, W + 1);
        run_op("deq",      32'd7,          32'd7,          32'd1,          32'd0,          1'b0, W + 1);
        run_op("dhex",     32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, W + 1);
        run_op("ddec",     32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0, W + 1);
        run_op("dzero",    32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1);

        // Backpressure on 3 / 10, with a stray request while busy.
        @(negedge clk);
        dividend = 32'd3;
        divisor  = 32'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            if (cyc == 5) begin
                dividend = 32'd99;
                divisor  = 32'd0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk("bp.calc_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp.latency", 64'(cyc), 64'(W + 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            dividend = 32'd50;
            divisor  = 32'd5;
            @(posedge clk);
            #1;
            chk("bp.hold_ov", 64'(out_valid), 64'd1);
            chk("bp.hold_quot", 64'(quotient), 64'd0);
            chk("bp.hold_rem", 64'(remainder), 64'd3);
            chk("bp.hold_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.ov_drop", 64'(out_valid), 64'd0);
        chk("bp.idle", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp.no_ghost", 64'(out_valid), 64'd0);

        // Abort 1000 / 3 after 10 calculation cycles.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.in_ready", 64'(in_ready), 64'd1);
        chk("abort.quot", 64'(quotient), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("d1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, W + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
